uart_rx_ovs: RTL and testbench

Parametrised oversampling UART receiver, successor to the team's fixed 8-bit shift receiver. Synchronises the serial line and detects start bits, rejecting false starts. Majority-votes each bit over its centre samples, checks stop and optional parity, and delivers frames through a valid/ready handshake with overrun detection. Sits between the RX pad and the SoC receive FIFO/register block. Runs on one clock; the baud generator supplies a sample strobe.

---
 rtl/uart_rx_ovs.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// -----------------------------------------------------------------------------
// uart_rx_ovs -- parametrised oversampling UART receiver
//
// Receives asynchronous serial frames (start, DATA_W data bits LSB first,
// optional parity, STOP_BITS stop bits) using a sample strobe running at
// OVS x baud. Each bit is decided by a majority vote over the centre half of
// its window; false starts are rejected at the start-bit midpoint. Received
// words are offered on a valid/ready handshake with overrun detection.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the
// data bits (sense chosen by PARITY_ODD). Without it parity_err is tied to 0.
//
// Parameters:
//   DATA_W      data bits per frame (5..9)
//   OVS         sample_tick strobes per bit period (even, >= 4)
//   STOP_BITS   stop bits checked (1 or 2)
//   PARITY_ODD  parity sense when parity is compiled in (0 even, 1 odd)
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-high
//   sample_tick  one-clk strobe at OVS x baud rate
//   rx           asynchronous serial input, idles high
//   rx_data      received word, stable while rx_valid=1
//   rx_valid     word available, held until accepted
//   rx_ready     consumer accepts when rx_valid & rx_ready
//   frame_err    one-clk pulse: stop bit sampled 0
//   parity_err   one-clk pulse: parity mismatch
//   overrun_err  one-clk pulse: frame completed while rx_valid still 1
//   busy         1 whenever the receiver is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_ovs #(
    parameter int DATA_W     = 8,
    parameter int OVS        = 16,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun_err,
    output logic              busy
);

    localparam int TW = $clog2(OVS);
    localparam int CW = TW + 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SW = 1;

    // START checks the line at the start-bit midpoint and then runs to the
    // end of the start bit, so every later window lines up with a bit period
    // and its centre samples straddle the bit midpoint.
    localparam logic [TW-1:0] T_MID       = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] T_START_END = TW'(OVS - 2);
    localparam logic [TW-1:0] T_WIN_END   = TW'(OVS - 1);
    localparam logic [TW-1:0] T_CTR_LO    = TW'(OVS/4);
    localparam logic [TW-1:0] T_CTR_HI    = TW'(OVS/4 + OVS/2 - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_W - 1);
    localparam logic [SW-1:0] STOP_LAST   = SW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              rx_meta;
    logic              rx_s;
    logic              rx_tick_prev;

    logic [TW-1:0]     tick_cnt;
    logic [CW-1:0]     ones_cnt;
    logic [BW-1:0]     bit_idx;
    logic [SW-1:0]     stop_idx;
    logic [DATA_W-1:0] shift_reg;

    logic              win_end;
    logic              bit_val;
    logic              frame_err_nxt;
    logic              done;
    logic              accept;

`ifdef UART_RX_PARITY_EN
    logic              parity_err_nxt;
    logic              discard;
`endif

    // Majority vote over the centre samples; a tie resolves to 1.
    function automatic logic vote(input logic [CW-1:0] ones);
        return ones >= CW'(OVS/4);
    endfunction

    function automatic logic in_centre(input logic [TW-1:0] t);
        return (t >= T_CTR_LO) && (t <= T_CTR_HI);
    endfunction

    function automatic logic par_expected(input logic [DATA_W-1:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    // ---- input synchroniser ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Line level at the previous tick. Cleared by reset so that a start bit
    // is only recognised after the line has been seen idle at least once.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_tick_prev <= 1'b0;
        end else if (sample_tick) begin
            rx_tick_prev <= rx_s;
        end
    end

    assign win_end = sample_tick && (tick_cnt == T_WIN_END);
    assign bit_val = vote(ones_cnt);
    assign accept  = rx_valid && rx_ready;
    assign busy    = (state != S_IDLE);

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM next state and strobes ----
    always_comb begin
        state_nxt     = state;
        frame_err_nxt = 1'b0;
        done          = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_nxt = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (sample_tick && !rx_s && rx_tick_prev) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (sample_tick) begin
                    if ((tick_cnt == T_MID) && rx_s) begin
                        state_nxt = S_IDLE;
                    end else if (tick_cnt == T_START_END) begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (win_end && (bit_idx == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (win_end) begin
                    state_nxt      = S_STOP;
                    parity_err_nxt = (bit_val != par_expected(shift_reg));
                end
            end
`endif
            S_STOP: begin
                if (win_end) begin
                    if (!bit_val) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = S_WAIT_IDLE;
                    end else if (stop_idx == STOP_LAST) begin
                        state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        done      = !discard;
`else
                        done      = 1'b1;
`endif
                    end
                end
            end
            S_WAIT_IDLE: begin
                // A held break stays here silently until the line goes high.
                if (sample_tick && rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---- window counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            ones_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
`ifdef UART_RX_PARITY_EN
            discard  <= 1'b0;
`endif
        end else if (sample_tick) begin
            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    ones_cnt <= '0;
                    bit_idx  <= '0;
                    stop_idx <= '0;
`ifdef UART_RX_PARITY_EN
                    discard  <= 1'b0;
`endif
                end
                S_START: begin
                    if (tick_cnt == T_START_END) begin
                        tick_cnt <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    tick_cnt <= '0;
                    ones_cnt <= '0;
                end
                default: begin
                    if (tick_cnt == T_WIN_END) begin
                        tick_cnt <= '0;
                        ones_cnt <= '0;
                        if (state == S_DATA) begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                        if (state == S_STOP) begin
                            stop_idx <= stop_idx + 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        if (state == S_PARITY) begin
                            discard <= parity_err_nxt;
                        end
`endif
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (in_centre(tick_cnt) && rx_s) begin
                            ones_cnt <= ones_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // ---- data shift register, LSB arrives first ----
    always_ff @(posedge clk) begin
        if (win_end && (state == S_DATA)) begin
            shift_reg <= {bit_val, shift_reg[DATA_W-1:1]};
        end
    end

    // ---- output handshake and error pulses ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_err_nxt;
            overrun_err <= 1'b0;
            if (done) begin
                // An accept on the completing clock frees the slot for the
                // new word, so it loads instead of overrunning.
                if (!rx_valid || accept) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ovs -- directed testbench for uart_rx_ovs (DATA_W=8, OVS=16,
// STOP_BITS=1). Drives serial frames tick by tick and checks received words,
// handshake behaviour and error pulses against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_ovs;

    localparam int DATA_W = 8;
    localparam int OVS    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_tick;
    logic              rx;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              parity_err;
    logic              overrun_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    int                n_valid = 0;
    int                n_ferr  = 0;
    int                n_perr  = 0;
    int                n_ovr   = 0;
    logic [DATA_W-1:0] last_data = '0;
    logic              valid_q = 1'b0;

`ifdef UART_RX_PARITY_EN
    logic              tx_par = 1'b0;
`endif

    uart_rx_ovs #(
        .DATA_W     (DATA_W),
        .OVS        (OVS),
        .STOP_BITS  (1),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // sample_tick high for one clk in every four
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    // Event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_valid && !valid_q) begin
            n_valid   = n_valid + 1;
            last_data = rx_data;
        end
        valid_q = rx_valid;
        if (frame_err)   n_ferr = n_ferr + 1;
        if (parity_err)  n_perr = n_perr + 1;
        if (overrun_err) n_ovr  = n_ovr + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after the n-th clock edge that carries a tick
    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (sample_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    // Returns just before the clock edge that will carry the next tick
    task automatic wait_pre_tick();
        do begin
            @(negedge clk);
            #1;
        end while (sample_tick !== 1'b1);
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        tick_wait(n);
    endtask

    // Start bit, data LSB first, optional parity, then stop_low ticks of 0
    // followed by stop_high ticks of 1. abort_bit >= 0 stops half way
    // through that data bit. corrupt inverts the first and last 3 ticks
    // of every data bit.
    task automatic send_frame(input logic [DATA_W-1:0] d, input bit corrupt,
                              input int stop_low, input int stop_high,
                              input int abort_bit);
        drive(1'b0, OVS);
        for (int i = 0; i < DATA_W; i++) begin
            if (i == abort_bit) begin
                drive(d[i], OVS/2);
                return;
            end
            if (corrupt) begin
                drive(~d[i], 3);
                drive(d[i], OVS - 6);
                drive(~d[i], 3);
            end else begin
                drive(d[i], OVS);
            end
        end
`ifdef UART_RX_PARITY_EN
        drive(tx_par, OVS);
`endif
        if (stop_low > 0)  drive(1'b0, stop_low);
        if (stop_high > 0) drive(1'b1, stop_high);
    endtask

    initial begin
        int b_valid, b_ferr, b_perr, b_ovr;

        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_valid", rx_valid, 1'b0);
        check_eq("rst_data", rx_data, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        check_eq("rst_perr", parity_err, 1'b0);
        check_eq("rst_ovr", overrun_err, 1'b0);
        rst = 1'b0;
        drive(1'b1, 20);

`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;   // even parity of 0xA5
`endif
        // Basic frame 0xA5
        b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr; b_ovr = n_ovr;
        send_frame(8'hA5, 1'b0, 0, OVS, -1);
        check_eq("a5_valid_latency", rx_valid, 1'b1);
        check_eq("a5_busy_after", busy, 1'b0);
        drive(1'b1, 4);
        check_eq("a5_valid_count", n_valid - b_valid, 1);
        check_eq("a5_data", last_data, 8'hA5);
        check_eq("a5_valid_cleared", rx_valid, 1'b0);
        check_eq("a5_errs", (n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr), 0);

        // Glitch shorter than half a bit
        b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr; b_ovr = n_ovr;
        drive(1'b0, 3);
        check_eq("glitch_busy_start", busy, 1'b1);
        drive(1'b1, OVS/2);
        check_eq("glitch_busy_end", busy, 1'b0);
        drive(1'b1, 2*OVS);
        check_eq("glitch_no_valid", n_valid - b_valid, 0);
        check_eq("glitch_errs", (n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr), 0);

        // Edge noise rejected by the centre vote
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;   // even parity of 0x3C
`endif
        b_valid = n_valid;
        send_frame(8'h3C, 1'b1, 0, OVS, -1);
        drive(1'b1, 4);
        check_eq("noise_valid_count", n_valid - b_valid, 1);
        check_eq("noise_data", last_data, 8'h3C);

        // Stop bit held low for 40 bit times, then a clean frame
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;   // even parity of 0x55
`endif
        b_valid = n_valid; b_ferr = n_ferr;
        send_frame(8'h55, 1'b0, 40*OVS, OVS, -1);
        check_eq("break_ferr_count", n_ferr - b_ferr, 1);
        check_eq("break_no_valid", n_valid - b_valid, 0);
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;   // even parity of 0x12
`endif
        send_frame(8'h12, 1'b0, 0, OVS, -1);
        drive(1'b1, 4);
        check_eq("after_break_data", last_data, 8'h12);
        check_eq("after_break_valid_count", n_valid - b_valid, 1);
        check_eq("after_break_ferr_count", n_ferr - b_ferr, 1);

        // Overrun with the consumer stalled
        rx_ready = 1'b0;
        b_valid = n_valid; b_ovr = n_ovr;
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;   // even parity of 0x11
`endif
        send_frame(8'h11, 1'b0, 0, OVS, -1);
        check_eq("ovr_first_valid", rx_valid, 1'b1);
        check_eq("ovr_first_data", rx_data, 8'h11);
        drive(1'b1, 4);
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;   // even parity of 0x22
`endif
        send_frame(8'h22, 1'b0, 0, OVS, -1);
        drive(1'b1, 2);
        check_eq("ovr_pulse_count", n_ovr - b_ovr, 1);
        check_eq("ovr_data_held", rx_data, 8'h11);
        check_eq("ovr_valid_held", rx_valid, 1'b1);

        // Accept on the same clock as completion: new word loads, no overrun
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b1;   // even parity of 0x44 is 0 -> use 0x44 with bit 0
        tx_par = 1'b0;
`endif
        send_frame(8'h44, 1'b0, 0, OVS - 1, -1);
        wait_pre_tick();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("prio_valid", rx_valid, 1'b1);
        check_eq("prio_data", rx_data, 8'h44);
        check_eq("prio_no_ovr", n_ovr - b_ovr, 1);
        @(posedge clk);
        #1;
        check_eq("prio_accept_clears", rx_valid, 1'b0);
        check_eq("prio_valid_rises", n_valid - b_valid, 1);
        drive(1'b1, 4);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has three ones, so even parity expects a 1
        b_valid = n_valid; b_perr = n_perr; b_ferr = n_ferr;
        tx_par = 1'b0;
        send_frame(8'h07, 1'b0, 0, OVS, -1);
        drive(1'b1, 4);
        check_eq("par_bad_perr", n_perr - b_perr, 1);
        check_eq("par_bad_no_valid", n_valid - b_valid, 0);
        check_eq("par_bad_no_ferr", n_ferr - b_ferr, 0);
        tx_par = 1'b1;
        send_frame(8'h07, 1'b0, 0, OVS, -1);
        drive(1'b1, 4);
        check_eq("par_good_perr", n_perr - b_perr, 1);
        check_eq("par_good_valid", n_valid - b_valid, 1);
        check_eq("par_good_data", last_data, 8'h07);
`endif

        // Reset in the middle of data bit 4, with a word still pending
        rx_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;   // even parity of 0x5A
`endif
        send_frame(8'h5A, 1'b0, 0, OVS, -1);
        check_eq("pre_rst_valid", rx_valid, 1'b1);
        drive(1'b1, 4);
        send_frame(8'hF0, 1'b0, 0, OVS, 4);
        check_eq("mid_rst_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", rx_valid, 1'b0);
        check_eq("mid_rst_data", rx_data, 8'h00);
        check_eq("mid_rst_busy", busy, 1'b0);
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_ready = 1'b1;
        drive(1'b1, OVS);
        b_valid = n_valid;
`ifdef UART_RX_PARITY_EN
        tx_par = 1'b0;   // even parity of 0x81
`endif
        send_frame(8'h81, 1'b0, 0, OVS, -1);
        drive(1'b1, 4);
        check_eq("post_rst_valid_count", n_valid - b_valid, 1);
        check_eq("post_rst_data", last_data, 8'h81);
        check_eq("post_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
